// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution (FIR) MAC engine.
package conv_pkg;

  // One-hot control states.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    MAC  = 3'b010,
    OUT  = 3'b100
  } state_t;

  // Accumulator width that can hold NTAPS full-scale products without overflow.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

  // Clamp a sign-extended value into the signed range of an ow-bit result.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] a, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (a > hi)      return hi;
    else if (a < lo) return lo;
    else             return a;
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Registered signed multiply-accumulate: product register feeds the accumulator one cycle later.
module conv_mac_unit #(
  parameter int DW    = 12,
  parameter int CW    = 12,
  parameter int ACC_W = 26
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [CW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [DW+CW-1:0] prod;
  logic                    prod_v;

  // Multiply stage then accumulate stage; clr drops any in-flight product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod   <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else if (clr) begin
      prod_v <= 1'b0;
      acc    <= '0;
    end else begin
      prod_v <= en;
      if (en)     prod <= a * b;
      if (prod_v) acc  <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_fir_mac.sv
// N-tap signed FIR engine: one serial MAC per clock, saturated output, valid/ready on both sides.
module conv_fir_mac
  import conv_pkg::*;
#(
  parameter int NTAPS = 4,
  parameter int DW    = 12,
  parameter int CW    = 12,
  parameter int OW    = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DW-1:0]     in_data,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic signed [CW-1:0]     coef_data,
  output logic                     coef_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OW-1:0]     out_data,
  output logic                     out_sat
);

  localparam int AW    = $clog2(NTAPS);
  localparam int KW    = $clog2(NTAPS + 1);
  localparam int ACC_W = acc_width(DW, CW, NTAPS);

  state_t                  state, state_nxt;
  logic [KW-1:0]           tap;
  logic signed [DW-1:0]    xline [NTAPS];
  logic signed [CW-1:0]    coef  [NTAPS];
  logic signed [DW-1:0]    x_sel;
  logic signed [CW-1:0]    c_sel;
  logic signed [ACC_W-1:0] acc;
  logic                    accept;
  logic                    coef_ok;
  logic                    mul_en;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign coef_ok  = (state == IDLE) && (KW'(coef_addr) < KW'(NTAPS));
  assign mul_en   = (state == MAC) && (tap < KW'(NTAPS));

  // The counter runs one step past the last tap so the final product can drain into acc.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (tap == KW'(NTAPS)) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and tap counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tap   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)      tap <= '0;
      else if (mul_en) tap <= tap + KW'(1);
    end
  end

  // Sample delay line, shifted once per accepted sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NTAPS; k++) xline[k] <= '0;
    end else if (accept) begin
      xline[0] <= in_data;
      for (int unsigned k = 1; k < NTAPS; k++) xline[k] <= xline[k-1];
    end
  end

  // Coefficient file; writes only land in IDLE, so they never disturb a running sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NTAPS; k++) coef[k] <= '0;
      coef[0]  <= CW'(2);
      coef[1]  <= CW'(-5);
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we & ~coef_ok;
      if (coef_we && coef_ok) coef[coef_addr] <= coef_data;
    end
  end

  // Operand select for the current tap.
  always_comb begin
    x_sel = '0;
    c_sel = '0;
    if (mul_en) begin
      x_sel = xline[tap[AW-1:0]];
      c_sel = coef[tap[AW-1:0]];
    end
  end

  conv_mac_unit #(
    .DW    (DW),
    .CW    (CW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (mul_en),
    .a     (x_sel),
    .b     (c_sel),
    .acc   (acc)
  );

  // acc is frozen in OUT, so the clamped view is stable under backpressure.
  assign out_valid = (state == OUT);
  assign out_data  = out_valid ? OW'(sat_clamp(64'(acc), OW)) : '0;
  assign out_sat   = out_valid && (sat_clamp(64'(acc), OW) != 64'(acc));

endmodule

// File: tb/tb_conv_fir_mac.sv
// Self-checking bench for conv_fir_mac with a reference model and result scoreboard.
module tb_conv_fir_mac;

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_ready;
  logic signed [11:0] in_data;
  logic               coef_we, coef_err;
  logic [1:0]         coef_addr;
  logic signed [11:0] coef_data;
  logic               out_valid, out_ready, out_sat;
  logic signed [12:0] out_data;

  // second instance with a non-power-of-two tap count to reach an out-of-range address
  logic               in_ready3, coef_we3, coef_err3, out_valid3, out_sat3;
  logic [1:0]         coef_addr3;
  logic signed [12:0] out_data3;

  int   npass = 0;
  int   ntotal = 0;
  int   mx[4];
  int   mc[4];
  exp_t sb[$];

  always #5 clk = ~clk;

  conv_fir_mac #(.NTAPS(4), .DW(12), .CW(12), .OW(13)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  conv_fir_mac #(.NTAPS(3), .DW(12), .CW(12), .OW(13)) dut3 (
    .clk(clk), .reset(reset), .in_valid(1'b0), .in_ready(in_ready3), .in_data(12'sd0),
    .coef_we(coef_we3), .coef_addr(coef_addr3), .coef_data(12'sd9), .coef_err(coef_err3),
    .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3), .out_sat(out_sat3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mx = '{0, 0, 0, 0};
    mc = '{2, -5, 0, 0};
  endtask

  function automatic exp_t model_step(input int x);
    longint s;
    exp_t   e;
    for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = x;
    s = 0;
    for (int k = 0; k < 4; k++) s += longint'(mx[k]) * longint'(mc[k]);
    if (s > 4095)       begin e.data = 4095;   e.sat = 1'b1; end
    else if (s < -4096) begin e.data = -4096;  e.sat = 1'b1; end
    else                begin e.data = int'(s); e.sat = 1'b0; end
    return e;
  endfunction

  task automatic send(input int x);
    int n = 0;
    in_valid = 1'b1;
    in_data  = 12'(x);
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      ntotal++;
      $display("FAIL send_timeout in_ready got %0b want 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model_step(x));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input string name, input int want_lat);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    ntotal++;
    if (!out_valid) begin
      $display("FAIL %s out_valid_timeout got %0b want 1", name, out_valid);
      return;
    end
    npass++;
    if (want_lat >= 0) begin
      ntotal++;
      if (lat !== want_lat) $display("FAIL %s latency got %0d want %0d", name, lat, want_lat);
      else npass++;
    end
    ntotal++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard_empty got %0d want 1", name, sb.size());
      return;
    end
    npass++;
    e = sb.pop_front();
    ntotal++;
    if (int'(out_data) !== e.data) $display("FAIL %s data got %0d want %0d", name, out_data, e.data);
    else npass++;
    ntotal++;
    if (out_sat !== e.sat) $display("FAIL %s sat got %0b want %0b", name, out_sat, e.sat);
    else npass++;
    tick();
    ntotal++;
    if (out_valid !== 1'b0) $display("FAIL %s valid_after_handshake got %0b want 0", name, out_valid);
    else npass++;
  endtask

  task automatic write_coef(input int addr, input int d, input bit exp_err);
    coef_we   = 1'b1;
    coef_addr = 2'(addr);
    coef_data = 12'(d);
    tick();
    coef_we = 1'b0;
    ntotal++;
    if (coef_err !== exp_err) $display("FAIL coef_err_pulse addr %0d got %0b want %0b", addr, coef_err, exp_err);
    else npass++;
    tick();
    ntotal++;
    if (coef_err !== 1'b0) $display("FAIL coef_err_width addr %0d got %0b want 0", addr, coef_err);
    else npass++;
    if (!exp_err) mc[addr] = d;
  endtask

  task automatic test_reset();
    ntotal++;
    if ({in_ready, out_valid, out_data, out_sat, coef_err} !== {1'b1, 1'b0, 13'd0, 1'b0, 1'b0})
      $display("FAIL reset_outputs got %b want %b", {in_ready, out_valid, out_data, out_sat, coef_err},
               {1'b1, 1'b0, 13'd0, 1'b0, 1'b0});
    else npass++;
    reset = 1'b1;
    tick();
    tick();
    ntotal++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_release got %b want 10", {in_ready, out_valid});
    else npass++;
  endtask

  task automatic test_impulse();
    send(100); recv("imp0", 5);
    send(0);   recv("imp1", 5);
    send(0);   recv("imp2", 5);
    send(0);   recv("imp3", 5);
  endtask

  task automatic test_ones();
    for (int k = 0; k < 4; k++) write_coef(k, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin send(1000); recv("ones", 5); end
  endtask

  task automatic test_saturation();
    write_coef(0, -2048, 1'b0);
    write_coef(1, 0, 1'b0);
    write_coef(2, 0, 1'b0);
    write_coef(3, 0, 1'b0);
    send(2047); recv("sat_neg", 5);
    send(2);    recv("edge_neg", 5);
    write_coef(0, 2047, 1'b0);
    send(2047); recv("sat_pos", 5);
    write_coef(0, 1, 1'b0);
    write_coef(1, 1, 1'b0);
    send(2047); recv("sum4094_a", 5);
    send(2047); recv("sum4094_b", 5);
    write_coef(2, 1, 1'b0);
    send(1);    recv("pre_edge_a", 5);
    send(2047); recv("pre_edge_b", 5);
    send(2047); recv("edge_pos", 5);
    send(2047); recv("over_pos", 5);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n = 0;
    out_ready = 1'b0;
    send(123);
    while (!out_valid && n < 50) begin tick(); n++; end
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 12'sd999;
      ntotal++;
      if ({out_valid, in_ready} !== 2'b10) $display("FAIL bp_hold%0d valid_ready got %b want 10", i, {out_valid, in_ready});
      else npass++;
      ntotal++;
      if (int'(out_data) !== e.data || out_sat !== e.sat)
        $display("FAIL bp_hold%0d data got %0d want %0d", i, out_data, e.data);
      else npass++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    void'(sb.pop_front());
    ntotal++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release got %b want 01", {out_valid, in_ready});
    else npass++;
    send(7); recv("bp_after", 5);
  endtask

  task automatic test_coef_err();
    send(300);
    write_coef(0, 77, 1'b1);
    recv("busy_write", -1);
    send(-40); recv("old_coefs", 5);
    coef_we3   = 1'b1;
    coef_addr3 = 2'd3;
    tick();
    coef_we3 = 1'b0;
    ntotal++;
    if (coef_err3 !== 1'b1) $display("FAIL addr_err got %0b want 1", coef_err3);
    else npass++;
    tick();
    ntotal++;
    if (coef_err3 !== 1'b0) $display("FAIL addr_err_width got %0b want 0", coef_err3);
    else npass++;
    coef_we3   = 1'b1;
    coef_addr3 = 2'd2;
    tick();
    coef_we3 = 1'b0;
    ntotal++;
    if (coef_err3 !== 1'b0) $display("FAIL addr_ok got %0b want 0", coef_err3);
    else npass++;
  endtask

  task automatic test_same_cycle();
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 12'sd3;
    in_valid  = 1'b1;
    in_data   = 12'sd10;
    mc[0] = 3;
    sb.push_back(model_step(10));
    tick();
    coef_we  = 1'b0;
    in_valid = 1'b0;
    ntotal++;
    if (coef_err !== 1'b0) $display("FAIL same_cycle_err got %0b want 0", coef_err);
    else npass++;
    recv("same_cycle", 5);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    send(55);
    tick();
    tick();
    reset = 1'b0;
    #1;
    sb.delete();
    model_reset();
    ntotal++;
    if ({out_valid, out_data, out_sat, in_ready} !== {1'b0, 13'd0, 1'b0, 1'b1})
      $display("FAIL mid_reset got %b want %b", {out_valid, out_data, out_sat, in_ready}, {1'b0, 13'd0, 1'b0, 1'b1});
    else npass++;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    ntotal++;
    if (seen !== 0 || in_ready !== 1'b1) $display("FAIL post_reset valid_cycles got %0d want 0", seen);
    else npass++;
    send(100); recv("imp_after_reset", 5);
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    out_ready  = 1'b1;
    coef_we3   = 1'b0;
    coef_addr3 = '0;
    model_reset();
    tick();
    tick();
    test_reset();
    test_impulse();
    test_ones();
    test_saturation();
    test_backpressure();
    test_coef_err();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
